// File: rtl/seq_detect_pkg.sv
// ============================================================================
//  Module   : seq_detect_pkg
//  Purpose  : Shared types, defaults and helpers for the programmable
//             serial pattern detector.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_detect_pkg;

  // Width of the configuration storage fields; MAX_LEN must not exceed this.
  localparam int SEQ_PAT_W = 32;
  localparam int SEQ_LEN_W = 8;

  localparam logic [15:0] DEF_PATTERN = 16'h00E8;
  localparam int          DEF_LEN     = 8;
  localparam logic        DEF_OVERLAP = 1'b1;

  typedef struct packed {
    logic [SEQ_PAT_W-1:0] pattern;
    logic [SEQ_LEN_W-1:0] len;
    logic                 overlap;
  } seq_cfg_t;

  function automatic int seq_len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Compares only the low 'len' bits; shifts of 'len' >= SEQ_PAT_W yield a full mask.
  function automatic logic seq_pattern_hit(input logic [SEQ_PAT_W-1:0] pattern,
                                           input logic [SEQ_LEN_W-1:0] len,
                                           input logic [SEQ_PAT_W-1:0] hist);
    logic [SEQ_PAT_W-1:0] mask;
    mask = ~({SEQ_PAT_W{1'b1}} << len);
    return ((hist ^ pattern) & mask) == '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_detect_hist.sv
// ============================================================================
//  Module   : seq_detect_hist
//  Purpose  : Serial history shift register with a saturating fill counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detect_hist #(
  parameter int MAX_LEN = 16,
  parameter int FILL_W  = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_shift,
  input  logic               i_bit,
  input  logic               i_fill_clr,
  output logic [FILL_W-1:0]  o_fill,
  output logic [MAX_LEN-1:0] o_hist_nxt,
  output logic [FILL_W-1:0]  o_fill_nxt
);

  logic [MAX_LEN-1:0] r_hist;
  logic [FILL_W-1:0]  r_fill;

  // Next values are exported so the match can be judged on post-shift state.
  assign o_hist_nxt = (r_hist << 1) | {{(MAX_LEN-1){1'b0}}, i_bit};
  assign o_fill_nxt = (r_fill == FILL_W'(MAX_LEN)) ? r_fill : r_fill + FILL_W'(1);
  assign o_fill     = r_fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_clear) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_shift) begin
      r_hist <= o_hist_nxt;
      r_fill <= i_fill_clr ? '0 : o_fill_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_detect_prog.sv
// ============================================================================
//  Module   : seq_detect_prog
//  Purpose  : Runtime-programmable serial bit-pattern detector with
//             overlap control. Define SEQ_DETECT_PROG_CNT_EN to build the
//             saturating match counter; otherwise match_cnt is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int               MAX_LEN     = 16,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(seq_detect_pkg::DEF_PATTERN),
  parameter int               DEF_LEN     = seq_detect_pkg::DEF_LEN,
  parameter logic             DEF_OVERLAP = seq_detect_pkg::DEF_OVERLAP,
  parameter int               CNT_W       = 16,
  localparam int              LEN_W       = seq_len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               data_in,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy
);

  localparam seq_cfg_t c_def_cfg = '{
    pattern: SEQ_PAT_W'(DEF_PATTERN),
    len:     SEQ_LEN_W'(DEF_LEN),
    overlap: DEF_OVERLAP
  };

  if (MAX_LEN < 2 || MAX_LEN > SEQ_PAT_W) begin : g_bad_max_len
    $error("seq_detect_prog: MAX_LEN out of supported range");
  end

  seq_cfg_t           r_cfg;
  seq_cfg_t           w_cfg_new;
  logic               r_match;
  logic               w_accept;
  logic               w_hit;
  logic               w_fill_clr;
  logic [LEN_W-1:0]   w_len_clamped;
  logic [LEN_W-1:0]   w_fill;
  logic [LEN_W-1:0]   w_fill_nxt;
  logic [MAX_LEN-1:0] w_hist_nxt;

  // A bit arriving together with a config load is dropped.
  assign w_accept = in_valid & ~cfg_load;

  always_comb begin
    w_len_clamped     = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
    w_cfg_new.pattern = SEQ_PAT_W'(cfg_pattern);
    w_cfg_new.len     = SEQ_LEN_W'(w_len_clamped);
    w_cfg_new.overlap = cfg_overlap;
  end

  always_comb begin
    w_hit = w_accept
         && (r_cfg.len != '0)
         && (SEQ_LEN_W'(w_fill_nxt) >= r_cfg.len)
         && seq_pattern_hit(r_cfg.pattern, r_cfg.len, SEQ_PAT_W'(w_hist_nxt));
    w_fill_clr = w_hit & ~r_cfg.overlap;
  end

  seq_detect_hist #(
    .MAX_LEN (MAX_LEN),
    .FILL_W  (LEN_W)
  ) u_hist (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (cfg_load),
    .i_shift    (w_accept),
    .i_bit      (data_in),
    .i_fill_clr (w_fill_clr),
    .o_fill     (w_fill),
    .o_hist_nxt (w_hist_nxt),
    .o_fill_nxt (w_fill_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg   <= c_def_cfg;
      r_match <= 1'b0;
    end else if (cfg_load) begin
      r_cfg   <= w_cfg_new;
      r_match <= 1'b0;
    end else begin
      r_match <= w_hit;
    end
  end

`ifdef SEQ_DETECT_PROG_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_hit && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign match_cnt = r_cnt;
`else
  assign match_cnt = '0;
`endif

  assign match = r_match;
  assign busy  = (w_fill != '0);

endmodule

`default_nettype wire

// File: tb/tb_seq_detect_prog.sv
// ============================================================================
//  Module   : tb_seq_detect_prog
//  Purpose  : Directed table-driven bench for seq_detect_prog.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_detect_prog;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_in = 1'b0;
  logic        in_valid = 1'b0;
  logic        cfg_load = 1'b0;
  logic [15:0] cfg_pattern = '0;
  logic [4:0]  cfg_len = '0;
  logic        cfg_overlap = 1'b0;

  logic        match, busy, match2, busy2;
  logic [15:0] match_cnt;
  logic [1:0]  match_cnt2;

  always #5 clk = ~clk;

  seq_detect_prog #(.MAX_LEN(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .match(match), .match_cnt(match_cnt), .busy(busy)
  );

  seq_detect_prog #(.MAX_LEN(16), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .match(match2), .match_cnt(match_cnt2), .busy(busy2)
  );

  typedef struct {
    logic        ld;
    logic [15:0] pat;
    logic [4:0]  len;
    logic        ov;
    logic        v;
    logic        d;
    logic        m;
    logic        b;
  } vec_t;

  vec_t vq[$];
  int   checks  = 0;
  int   errors  = 0;
  int   exp_cnt = 0;

  function automatic vec_t mkbit(logic v, logic d, logic m, logic b);
    vec_t t;
    t.ld = 1'b0; t.pat = '0; t.len = '0; t.ov = 1'b0;
    t.v = v; t.d = d; t.m = m; t.b = b;
    return t;
  endfunction

  // Loads carry a valid '1' bit that must be discarded.
  function automatic vec_t mkload(logic [15:0] pat, logic [4:0] len, logic ov);
    vec_t t;
    t.ld = 1'b1; t.pat = pat; t.len = len; t.ov = ov;
    t.v = 1'b1; t.d = 1'b1; t.m = 1'b0; t.b = 1'b0;
    return t;
  endfunction

  function automatic void add_stream(logic [15:0] bits, int n, logic match_last);
    logic [15:0] w;
    w = bits;
    for (int i = n - 1; i >= 0; i--)
      vq.push_back(mkbit(1'b1, w[i], (i == 0) ? match_last : 1'b0, 1'b1));
  endfunction

  function automatic int cnt_exp(int w);
`ifdef SEQ_DETECT_PROG_CNT_EN
    int lim;
    lim = (1 << w) - 1;
    return (exp_cnt > lim) ? lim : exp_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic m, input logic b);
    if (m) exp_cnt++;
    chk($sformatf("%s match", tag), 32'(match), 32'(m));
    chk($sformatf("%s busy", tag), 32'(busy), 32'(b));
    chk($sformatf("%s match2", tag), 32'(match2), 32'(m));
    chk($sformatf("%s cnt", tag), 32'(match_cnt), 32'(cnt_exp(16)));
    chk($sformatf("%s cnt2", tag), 32'(match_cnt2), 32'(cnt_exp(2)));
  endtask

  task automatic run_vec(input vec_t t, input string tag);
    @(negedge clk);
    cfg_load    = t.ld;
    cfg_pattern = t.pat;
    cfg_len     = t.len;
    cfg_overlap = t.ov;
    in_valid    = t.v;
    data_in     = t.d;
    @(posedge clk);
    #1;
    check_outputs(tag, t.m, t.b);
  endtask

  initial begin
    // Default pattern E8, one pulse after the 8th bit, then idle.
    add_stream(16'h00E8, 8, 1'b1);
    vq.push_back(mkbit(1'b0, 1'b0, 1'b0, 1'b1));
    // Overlapping 2'b11: three back-to-back pulses.
    vq.push_back(mkload(16'h0003, 5'd2, 1'b1));
    vq.push_back(mkbit(1'b1, 1'b1, 1'b0, 1'b1));
    vq.push_back(mkbit(1'b1, 1'b1, 1'b1, 1'b1));
    vq.push_back(mkbit(1'b1, 1'b1, 1'b1, 1'b1));
    vq.push_back(mkbit(1'b1, 1'b1, 1'b1, 1'b1));
    vq.push_back(mkbit(1'b0, 1'b0, 1'b0, 1'b1));
    // Non-overlapping 2'b11: pulses after bits 2 and 4, fill cleared on each.
    vq.push_back(mkload(16'h0003, 5'd2, 1'b0));
    vq.push_back(mkbit(1'b1, 1'b1, 1'b0, 1'b1));
    vq.push_back(mkbit(1'b1, 1'b1, 1'b1, 1'b0));
    vq.push_back(mkbit(1'b1, 1'b1, 1'b0, 1'b1));
    vq.push_back(mkbit(1'b1, 1'b1, 1'b1, 1'b0));
    vq.push_back(mkbit(1'b0, 1'b0, 1'b0, 1'b0));
    // E8 with in_valid gaps of 1..3 cycles.
    vq.push_back(mkload(16'h00E8, 5'd8, 1'b1));
    begin
      logic [7:0] gb;
      gb = 8'hE8;
      for (int i = 7; i >= 0; i--) begin
        vq.push_back(mkbit(1'b1, gb[i], (i == 0), 1'b1));
        if (i != 0)
          for (int g = 0; g < ((7 - i) % 3) + 1; g++)
            vq.push_back(mkbit(1'b0, 1'b1, 1'b0, 1'b1));
      end
    end
    vq.push_back(mkbit(1'b0, 1'b0, 1'b0, 1'b1));
    // Length 0 disables detection.
    vq.push_back(mkload(16'h0000, 5'd0, 1'b1));
    for (int i = 0; i < 4; i++) vq.push_back(mkbit(1'b1, 1'b0, 1'b0, 1'b1));
    // Length 31 clamps to 16.
    vq.push_back(mkload(16'hA5C3, 5'd31, 1'b1));
    add_stream(16'hA5C3, 16, 1'b1);
    vq.push_back(mkbit(1'b0, 1'b0, 1'b0, 1'b1));
    // Reload after 5 bits restarts the fill; a fresh E8 then matches.
    vq.push_back(mkload(16'h00E8, 5'd8, 1'b1));
    add_stream(16'h001D, 5, 1'b0);
    vq.push_back(mkload(16'h00E8, 5'd8, 1'b1));
    add_stream(16'h0000, 3, 1'b0);
    add_stream(16'h00E8, 8, 1'b1);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++)
      run_vec(vq[i], $sformatf("vec%0d", i));

    // Asynchronous reset while match is high, mid-stream.
    run_vec(mkload(16'h0003, 5'd2, 1'b1), "rst_ld");
    run_vec(mkbit(1'b1, 1'b1, 1'b0, 1'b1), "rst_b1");
    run_vec(mkbit(1'b1, 1'b1, 1'b1, 1'b1), "rst_b2");
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("async match", 32'(match), 32'd0);
    chk("async busy", 32'(busy), 32'd0);
    chk("async cnt", 32'(match_cnt), 32'd0);
    chk("async cnt2", 32'(match_cnt2), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // Stale 2'b11 config would fire on the second bit; defaults must not.
    run_vec(mkbit(1'b1, 1'b1, 1'b0, 1'b1), "post_b1");
    run_vec(mkbit(1'b1, 1'b1, 1'b0, 1'b1), "post_b2");
    run_vec(mkbit(1'b1, 1'b1, 1'b0, 1'b1), "post_b3");
    run_vec(mkbit(1'b1, 1'b0, 1'b0, 1'b1), "post_b4");
    run_vec(mkbit(1'b1, 1'b1, 1'b0, 1'b1), "post_b5");
    run_vec(mkbit(1'b1, 1'b0, 1'b0, 1'b1), "post_b6");
    run_vec(mkbit(1'b1, 1'b0, 1'b0, 1'b1), "post_b7");
    run_vec(mkbit(1'b1, 1'b0, 1'b1, 1'b1), "post_b8");
    run_vec(mkbit(1'b0, 1'b0, 1'b0, 1'b1), "post_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_detect_prog.md
# seq_detect_prog

Runtime-programmable serial bit-pattern detector: the parametrised successor to the team's fixed 8-bit serial sequence detector. It compares a qualified serial bit stream against a loadable pattern of 1..MAX_LEN bits and pulses `match` when the pattern completes. Overlapping or non-overlapping detection is selected at runtime, and an optional saturating match counter is available. It sits between a serial line front-end (deserialiser or debounced input) and control logic that reacts to frame/sync words.

## Interface
- `MAX_LEN`, 16: longest supported pattern, in bits (≥2).
- `DEF_PATTERN`, 16'h00E8: pattern loaded at reset, right-aligned.
- `DEF_LEN`, 8: pattern length loaded at reset.
- `DEF_OVERLAP`, 1'b1: overlap mode loaded at reset.
- `CNT_W`, 16: width of `match_cnt`.
- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `data_in`, in, 1: serial bit, sampled only when `in_valid`=1.
- `in_valid`, in, 1: qualifies `data_in` on this edge.
- `cfg_load`, in, 1: single-cycle strobe that latches `cfg_*`.
- `cfg_pattern`, in, MAX_LEN: new pattern, right-aligned.
- `cfg_len`, in, LEN_W: new length. LEN_W = $clog2(MAX_LEN+1).
- `cfg_overlap`, in, 1: 1 = overlapping detection, 0 = non-overlapping.
- `match`, out, 1: registered one-cycle pulse per detection.
- `match_cnt`, out, CNT_W: saturating detection count.
- `busy`, out, 1: 1 while the history holds at least one bit (fill ≠ 0).

## Operation
- **Bit order:** first-received bit of the pattern is `cfg_pattern[len-1]`; last-received bit is `cfg_pattern[0]`.
- **Per accepted bit** (`in_valid`=1 and `cfg_load`=0):
  - shift into history register `hist[MAX_LEN-1:0]` at bit 0;
  - `fill` increments, saturating at MAX_LEN.
- **Match condition**, evaluated on the post-shift values: `fill ≥ len` and `hist[len-1:0] == pattern[len-1:0]`.
- **Overlap mode:**
  - overlap=1: history and `fill` are kept after a match.
  - overlap=0: `fill` is cleared to 0 on the match edge, so the next match needs `len` fresh bits.
- **Configuration:**
  - `cfg_load`=1 latches pattern, len and overlap; clears `hist`, `fill` and `match`; leaves `match_cnt` unchanged.
  - Any bit presented in the same cycle as `cfg_load` is discarded.
- **Length rules:**
  - `cfg_len` = 0: detection is disabled and `match` stays 0.
  - `cfg_len` > MAX_LEN: clamped to MAX_LEN at load.
  - Pattern bits above `len` are ignored.
- **Counter:** `match_cnt` increments on each `match` pulse and saturates at 2^CNT_W−1.
- **Reset values:** `match`=0, `match_cnt`=0, `busy`=0, `hist`=0, `fill`=0; config registers = DEF_*.

## Timing
- **Latency:** bit accepted on edge k completes a match → `match`=1 for cycle k..k+1 (registered, one clock after sampling).
- **Back-to-back matches:** consecutive accepted bits that each complete a match (overlap=1) give `match` high for consecutive cycles, one count per cycle.
- **Idle:** `in_valid`=0 holds all state; `match` returns to 0 after its single cycle.
- **Counter timing:** `match_cnt` updates on the same edge that raises `match`.
- **Config timing:** a new configuration takes effect for the first bit accepted after the `cfg_load` edge.
- **Reset mid-stream:** asynchronous assertion clears outputs immediately. State after deassertion is as at reset.

## Configuration
- **`SEQ_DETECT_PROG_CNT_EN` defined:** the `match_cnt` register is implemented as specified.
- **Not defined:** the `match_cnt` port remains and is driven constant 0, and no counter flops are built. `match` behaviour is identical in both builds.

## Structure
- **Package `seq_detect_pkg`:**
  - `LEN_W` computation function;
  - default constants DEF_PATTERN, DEF_LEN, DEF_OVERLAP;
  - packed struct `seq_cfg_t` {pattern, len, overlap}.
- **Sub-module `seq_detect_hist`:**
  - contains the history shift register and saturating `fill` counter, with clear/shift controls;
  - the top level holds the config register, comparison, `match` register and counter.

## Test plan
- **Default pattern:** reset defaults, stream 1,1,1,0,1,0,0,0 with `in_valid`=1 → `match` pulses once, the cycle after the 8th bit; `match_cnt`=1.
- **Overlap vs non-overlap:**
  - load pattern 2'b11, len 2, overlap=1, stream 1,1,1,1 → 3 pulses on consecutive cycles;
  - same with overlap=0 → 2 pulses, after bits 2 and 4.
- **Valid gaps:** E8 stream with `in_valid`=0 gaps of 1–3 cycles between bits → exactly one pulse, one cycle after the last valid bit.
- **Reload mid-pattern:** after 5 bits of E8, pulse `cfg_load` with the same pattern, then send the remaining 3 bits → no match, `busy` shows fill restarted; a full E8 stream then matches.
- **Limits:**
  - CNT_W=2: 5 matches → `match_cnt`=3;
  - `cfg_len`=0 with any stream → no pulse;
  - `cfg_len`=31 with MAX_LEN=16 → behaves as length 16.
- **Async reset:** assert `rst_n`=0 mid-stream, 3 bits into a pattern → outputs 0 immediately; after release, config = defaults and no spurious match.
